trigger_burst_scheduler: RTL and testbench

//  Sequences waveform playback from one selected trigger source (manual toggle, external edge, internal timer).
//  Arm/abort control, programmable trigger delay, N-cycle burst count.

---
 rtl/trigger_burst_scheduler.sv | 162 ++++++++++++++++
 tb/tb_trigger_burst_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/trigger_burst_scheduler.sv
// rtl/trigger_burst_scheduler.sv - trigger source select, delay and burst sequencing for playback
// Optional feature macro: TRIG_AUTO_REARM_EN (end-of-burst returns to ARMED instead of IDLE).
module trigger_burst_scheduler #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [1:0]         Src_Sel,
  input  logic               Man_Trig,
  input  logic               Ext_Trig,
  input  logic [CNT_W-1:0]   Timer_Period,
  input  logic [CNT_W-1:0]   Delay_Cnt,
  input  logic [BURST_W-1:0] Burst_Num,
  input  logic               Arm,
  input  logic               Abort,
  input  logic               Play_Done,
  output logic               Play_Start,
  output logic               Armed,
  output logic               Busy,
  output logic               Trig_Miss
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_START,
    S_RUN
  } state_t;

  state_t             state;
  logic               man_q, man_h, ext_q, ext_h;
  logic [1:0]         src_l;
  logic [CNT_W-1:0]   dly_l, per_l, timer, dly_cnt, per_m1;
  logic [BURST_W-1:0] burst_l, burst_eff, remaining;
  logic               play_start_q, armed_q, busy_q, trig_miss_q;
  logic               man_evt, ext_evt, tmr_evt, evt;

  always_comb begin
    per_m1    = (per_l == '0) ? '0 : per_l - CNT_W'(1);
    burst_eff = (burst_l == '0) ? BURST_W'(1) : burst_l;
    man_evt   = man_q ^ man_h;
    ext_evt   = ext_q & ~ext_h;
    tmr_evt   = (state == S_ARMED) && (timer == per_m1);
    case (src_l)
      2'd0:    evt = man_evt;
      2'd1:    evt = ext_evt;
      2'd2:    evt = tmr_evt;
      default: evt = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= S_IDLE;
      man_q        <= 1'b0;
      man_h        <= 1'b0;
      ext_q        <= 1'b0;
      ext_h        <= 1'b0;
      src_l        <= '0;
      dly_l        <= '0;
      per_l        <= '0;
      burst_l      <= '0;
      timer        <= '0;
      dly_cnt      <= '0;
      remaining    <= '0;
      play_start_q <= 1'b0;
      armed_q      <= 1'b0;
      busy_q       <= 1'b0;
      trig_miss_q  <= 1'b0;
    end else begin
      // History runs in every state so arming never sees a stale edge.
      man_q        <= Man_Trig;
      man_h        <= man_q;
      ext_q        <= Ext_Trig;
      ext_h        <= ext_q;
      play_start_q <= 1'b0;
      trig_miss_q  <= 1'b0;
      timer        <= '0;
      if (Abort) begin
        state     <= S_IDLE;
        armed_q   <= 1'b0;
        busy_q    <= 1'b0;
        dly_cnt   <= '0;
        remaining <= '0;
      end else begin
        trig_miss_q <= busy_q & evt;
        case (state)
          S_IDLE: begin
            if (Arm) begin
              src_l   <= Src_Sel;
              dly_l   <= Delay_Cnt;
              per_l   <= Timer_Period;
              burst_l <= Burst_Num;
              state   <= S_ARMED;
              armed_q <= 1'b1;
            end
          end
          S_ARMED: begin
            if (evt) begin
              armed_q   <= 1'b0;
              busy_q    <= 1'b1;
              remaining <= burst_eff;
              if (dly_l == '0) begin
                state        <= S_START;
                play_start_q <= 1'b1;
              end else begin
                state   <= S_DELAY;
                dly_cnt <= dly_l;
              end
            end else if (timer != '1) begin
              timer <= timer + CNT_W'(1);
            end
          end
          S_DELAY: begin
            if (dly_cnt <= CNT_W'(1)) begin
              dly_cnt      <= '0;
              state        <= S_START;
              play_start_q <= 1'b1;
            end else begin
              dly_cnt <= dly_cnt - CNT_W'(1);
            end
          end
          S_START: begin
            state <= S_RUN;
          end
          S_RUN: begin
            if (Play_Done) begin
              if (remaining <= BURST_W'(1)) begin
                remaining <= '0;
                busy_q    <= 1'b0;
`ifdef TRIG_AUTO_REARM_EN
                state     <= S_ARMED;
                armed_q   <= 1'b1;
`else
                state     <= S_IDLE;
`endif
              end else begin
                remaining    <= remaining - BURST_W'(1);
                state        <= S_START;
                play_start_q <= 1'b1;
              end
            end
          end
          default: begin
            state   <= S_IDLE;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Abort landing in the START cycle must still cancel that start.
  assign Play_Start = play_start_q & ~Abort;
  assign Armed      = armed_q;
  assign Busy       = busy_q;
  assign Trig_Miss  = trig_miss_q;

endmodule

// File: tb/tb_trigger_burst_scheduler.sv
// tb/tb_trigger_burst_scheduler.sv - directed vector table plus multi-cycle sequences
module tb_trigger_burst_scheduler;

`ifdef TRIG_AUTO_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset, Man_Trig, Ext_Trig, Arm, Abort, Play_Done;
  logic [1:0]  Src_Sel;
  logic [15:0] Timer_Period, Delay_Cnt;
  logic [7:0]  Burst_Num;
  logic        Play_Start, Armed, Busy, Trig_Miss;

  int n_cmp = 0;
  int n_bad = 0;

  trigger_burst_scheduler #(.CNT_W(16), .BURST_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .Src_Sel(Src_Sel), .Man_Trig(Man_Trig),
    .Ext_Trig(Ext_Trig), .Timer_Period(Timer_Period), .Delay_Cnt(Delay_Cnt),
    .Burst_Num(Burst_Num), .Arm(Arm), .Abort(Abort), .Play_Done(Play_Done),
    .Play_Start(Play_Start), .Armed(Armed), .Busy(Busy), .Trig_Miss(Trig_Miss)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit        rst, arm, abort, ext, done;
    bit [1:0]  src;
    bit [15:0] dly;
    bit [7:0]  burst;
    bit [3:0]  exp;   // {Play_Start, Armed, Busy, Trig_Miss}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, arm, abort, ext, done, input bit [1:0] src,
                     input bit [15:0] dly, input bit [7:0] burst, input bit [3:0] exp);
    vec_t v;
    v.rst = rst; v.arm = arm; v.abort = abort; v.ext = ext; v.done = done;
    v.src = src; v.dly = dly; v.burst = burst; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    Reset = 0; Arm = 0; Abort = 0; Play_Done = 0; Ext_Trig = 0; Man_Trig = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1;
    step();
    Reset = 0;
  endtask

  int n;
  bit [3:0] eob;

  initial begin
    idle_inputs();
    Reset = 1; Src_Sel = 0; Timer_Period = 0; Delay_Cnt = 0; Burst_Num = 0;
    eob = {1'b0, REARM, 2'b00};

    // src=1 D=3 N=1: latency and single start; Arm while busy ignored
    add(1,0,0,0,0, 1,3,1, 4'b0000);
    add(0,1,0,0,0, 1,3,1, 4'b0100);
    add(0,0,0,1,0, 1,3,1, 4'b0100);
    add(0,0,0,1,0, 1,3,1, 4'b0010);
    add(0,1,0,1,0, 1,3,1, 4'b0010);
    add(0,0,0,1,0, 1,3,1, 4'b0010);
    add(0,0,0,1,0, 1,3,1, 4'b1010);
    add(0,0,0,1,1, 1,3,1, 4'b0010);
    add(0,0,0,0,0, 1,3,1, 4'b0010);
    add(0,0,0,0,1, 1,3,1, eob);
    add(0,0,1,0,0, 1,3,1, 4'b0000);
    add(0,0,0,1,1, 1,3,1, 4'b0000);
    add(0,0,0,0,0, 1,3,1, 4'b0000);
    // second external edge during DELAY
    add(0,1,0,0,0, 1,3,1, 4'b0100);
    add(0,0,0,1,0, 1,3,1, 4'b0100);
    add(0,0,0,0,0, 1,3,1, 4'b0010);
    add(0,0,0,1,0, 1,3,1, 4'b0010);
    add(0,0,0,1,0, 1,3,1, 4'b0011);
    add(0,0,0,1,0, 1,3,1, 4'b1010);
    add(0,0,0,0,0, 1,3,1, 4'b0010);
    add(0,0,0,0,1, 1,3,1, eob);
    add(0,0,1,0,0, 1,3,1, 4'b0000);
    // Abort + Arm together in DELAY
    add(0,1,0,0,0, 1,3,1, 4'b0100);
    add(0,0,0,1,0, 1,3,1, 4'b0100);
    add(0,0,0,1,0, 1,3,1, 4'b0010);
    add(0,1,1,1,0, 1,3,1, 4'b0000);
    add(0,0,0,1,0, 1,3,1, 4'b0000);
    add(0,0,0,0,0, 1,3,1, 4'b0000);
    add(0,0,0,0,0, 1,3,1, 4'b0000);
    add(0,0,0,0,0, 1,3,1, 4'b0000);
    // Burst_Num=0 acts as 1, zero delay
    add(0,1,0,0,0, 1,0,0, 4'b0100);
    add(0,0,0,1,0, 1,0,0, 4'b0100);
    add(0,0,0,1,0, 1,0,0, 4'b1010);
    add(0,0,0,0,0, 1,0,0, 4'b0010);
    add(0,0,0,0,1, 1,0,0, eob);
    add(0,0,1,0,0, 1,0,0, 4'b0000);
    // Reset in the middle of RUN
    add(0,1,0,0,0, 1,0,2, 4'b0100);
    add(0,0,0,1,0, 1,0,2, 4'b0100);
    add(0,0,0,1,0, 1,0,2, 4'b1010);
    add(0,0,0,0,0, 1,0,2, 4'b0010);
    add(1,0,0,0,0, 1,0,2, 4'b0000);
    add(0,0,0,0,1, 1,0,2, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      Reset = vecs[i].rst; Arm = vecs[i].arm; Abort = vecs[i].abort;
      Ext_Trig = vecs[i].ext; Play_Done = vecs[i].done; Man_Trig = 0;
      Src_Sel = vecs[i].src; Delay_Cnt = vecs[i].dly; Burst_Num = vecs[i].burst;
      step();
      check($sformatf("vec%0d", i), {28'd0, Play_Start, Armed, Busy, Trig_Miss}, {28'd0, vecs[i].exp});
    end

    // Manual source, D=0, N=3
    do_reset();
    Src_Sel = 0; Delay_Cnt = 0; Burst_Num = 3; Arm = 1;
    step();
    Arm = 0; Man_Trig = 1;
    step();
    check("man_wait", {30'd0, Play_Start, Armed}, 32'b01);
    step();
    check("man_first", {30'd0, Play_Start, Busy}, 32'b11);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("man_run%0d", i), {30'd0, Play_Start, Busy}, 32'b01);
      Play_Done = 1;
      step();
      Play_Done = 0;
      if (i < 2) check($sformatf("man_next%0d", i), {30'd0, Play_Start, Busy}, 32'b11);
      else check("man_end", {29'd0, Play_Start, Busy, Armed}, {29'd0, 1'b0, 1'b0, REARM});
    end
    Abort = 1;
    step();
    Abort = 0;

    // Abort during the START cycle cancels the visible pulse
    do_reset();
    Src_Sel = 1; Delay_Cnt = 0; Burst_Num = 1; Arm = 1;
    step();
    Arm = 0; Ext_Trig = 1;
    step();
    step();
    check("abort_pre", {31'd0, Play_Start}, 32'd1);
    Abort = 1;
    #1;
    check("abort_gate", {31'd0, Play_Start}, 32'd0);
    step();
    Abort = 0; Ext_Trig = 0;
    check("abort_idle", {29'd0, Play_Start, Armed, Busy}, 32'd0);

    // Internal timer, period 10
    do_reset();
    Src_Sel = 2; Timer_Period = 10; Delay_Cnt = 0; Burst_Num = 1; Arm = 1;
    step();
    Arm = 0;
    n = 0;
    while (!Play_Start && n < 40) begin step(); n++; end
    check("timer_spacing", n, 10);
    step();
    Play_Done = 1;
    step();
    Play_Done = 0;
    check("timer_eob_armed", {31'd0, Armed}, {31'd0, REARM});
    n = 0;
    while (!Play_Start && n < 15) begin step(); n++; end
    if (REARM) check("timer_rearm_spacing", n, 10);
    else check("timer_no_rearm", {31'd0, Play_Start}, 32'd0);
    Abort = 1;
    step();
    Abort = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
